// File: rtl/ascon_state_unloader_if.sv
// Slice stream in, reconstructed state and valid/ready handshake out.
// The slave modport is the unloader's view of the bundle.
interface ascon_state_unloader_if #(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned SLICE_W = 1
);
  logic                   cap_start;
  logic                   slice_en;
  logic [5*SLICE_W-1:0]   slice_in;
  logic [WORD_W-1:0]      x0;
  logic [WORD_W-1:0]      x1;
  logic [WORD_W-1:0]      x2;
  logic [WORD_W-1:0]      x3;
  logic [WORD_W-1:0]      x4;
  logic                   state_valid;
  logic                   state_ready;

  modport master (
    output cap_start, slice_en, slice_in, state_ready,
    input  x0, x1, x2, x3, x4, state_valid
  );

  modport slave (
    input  cap_start, slice_en, slice_in, state_ready,
    output x0, x1, x2, x3, x4, state_valid
  );
endinterface

// File: rtl/ascon_state_unloader.sv
// Rebuilds the five Ascon state words from the bit-sliced permutation output
// stream (MSB-first per word) and presents them over a valid/ready handshake.
module ascon_state_unloader #(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned SLICE_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ascon_state_unloader_if.slave  bus,
  input  logic                   clr_err,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned BEATS = WORD_W / SLICE_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] START_CNT = (BEATS > 1) ? CNT_W'(1) : '0;

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  // A single-beat capture completes on its start beat.
  localparam state_t START_ST = (BEATS > 1) ? CAPTURE : HOLD;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] r_x [5];
  logic [WORD_W-1:0] w_x_shift [5];
  logic              r_ovr;
  logic              w_shift;
  logic              w_set_ovr;
  logic              w_start;
  logic              w_valid;
  logic              w_busy;

  assign w_start = bus.cap_start & bus.slice_en;

  // Next value of each word when a beat is accepted.
  generate
    if (BEATS == 1) begin : g_full
      always_comb begin
        for (int unsigned k = 0; k < 5; k++)
          w_x_shift[k] = bus.slice_in[(4-k)*SLICE_W +: SLICE_W];
      end
    end else begin : g_shift
      always_comb begin
        for (int unsigned k = 0; k < 5; k++)
          w_x_shift[k] = {r_x[k][WORD_W-SLICE_W-1:0],
                          bus.slice_in[(4-k)*SLICE_W +: SLICE_W]};
      end
    end
  endgenerate

  // State and beat counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic plus shift/overrun strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_shift     = 1'b1;
          w_state_nxt = START_ST;
          w_cnt_nxt   = START_CNT;
        end
      end
      CAPTURE: begin
        if (bus.slice_en) begin
          w_shift   = 1'b1;
          w_set_ovr = bus.cap_start;
          if (r_cnt == LAST_CNT) begin
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.state_ready) begin
          // Handshake completes; a start beat in the same cycle is kept.
          w_state_nxt = IDLE;
          if (w_start) begin
            w_shift     = 1'b1;
            w_state_nxt = START_ST;
            w_cnt_nxt   = START_CNT;
          end
        end else if (w_start) begin
          w_set_ovr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    w_valid = (r_state == HOLD);
    w_busy  = (r_state == CAPTURE);
  end

  // Word shift registers; frozen outside accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < 5; k++) r_x[k] <= '0;
    end else if (w_shift) begin
      for (int unsigned k = 0; k < 5; k++) r_x[k] <= w_x_shift[k];
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ovr <= 1'b0;
    else if (w_set_ovr) r_ovr <= 1'b1;
    else if (clr_err)   r_ovr <= 1'b0;
  end

  assign bus.x0          = r_x[0];
  assign bus.x1          = r_x[1];
  assign bus.x2          = r_x[2];
  assign bus.x3          = r_x[3];
  assign bus.x4          = r_x[4];
  assign bus.state_valid = w_valid;
  assign busy            = w_busy;
  assign overrun         = r_ovr;

endmodule
